// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element table for the SRAM macro BIST controller.
package sram_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // bit 1 marks a read, bit 0 selects D1 over D0
    typedef enum logic [1:0] {
        OP_W0 = 2'b00,
        OP_W1 = 2'b01,
        OP_R0 = 2'b10,
        OP_R1 = 2'b11
    } op_e;

    localparam int         C_MARCH_OPS_PER_ADDR = 10;
    localparam int         C_MARCH_ELEMS        = 6;
    localparam logic [2:0] C_LAST_ELEM          = 3'(C_MARCH_ELEMS - 1);

    typedef struct packed {
        logic down;
        logic two_ops;
        op_e  op0;
        op_e  op1;
    } march_elem_t;

    function automatic march_elem_t march_elem(input logic [2:0] idx);
        march_elem_t e;
        case (idx)
            3'd0:    e = '{down: 1'b0, two_ops: 1'b0, op0: OP_W0, op1: OP_W0};
            3'd1:    e = '{down: 1'b0, two_ops: 1'b1, op0: OP_R0, op1: OP_W1};
            3'd2:    e = '{down: 1'b0, two_ops: 1'b1, op0: OP_R1, op1: OP_W0};
            3'd3:    e = '{down: 1'b1, two_ops: 1'b1, op0: OP_R0, op1: OP_W1};
            3'd4:    e = '{down: 1'b1, two_ops: 1'b1, op0: OP_R1, op1: OP_W0};
            default: e = '{down: 1'b0, two_ops: 1'b0, op0: OP_R0, op1: OP_R0};
        endcase
        return e;
    endfunction

    function automatic logic op_is_read(input op_e op);
        return op[1];
    endfunction

    function automatic logic op_data_sel(input op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Loadable up/down address counter; first/last flag the element boundaries
// for the current direction so the sequencer never relies on wrap-around.
module sram_bist_addr_gen #(
    parameter int P_ADDR_WIDTH = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    load_down,
    input  logic                    step,
    input  logic                    down,
    output logic [P_ADDR_WIDTH-1:0] addr,
    output logic                    first,
    output logic                    last
);

    localparam logic [P_ADDR_WIDTH-1:0] C_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_down ? C_MAX : '0;
        end else if (step) begin
            addr <= down ? addr - 1'b1 : addr + 1'b1;
        end
    end

    assign first = down ? (addr == C_MAX) : (addr == '0);
    assign last  = down ? (addr == '0) : (addr == C_MAX);

endmodule

// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST initiator for a 1P SRAM macro, stop-on-first-fail.
// Optional second checkerboard-background pass: define SRAM_BIST_CKBD_EN.
module sram_march_bist_ctrl
    import sram_bist_pkg::*;
#(
    parameter int P_DATA_WIDTH = 24,
    parameter int P_ADDR_WIDTH = 14
) (
    input  logic                    A_CLK,
    input  logic                    A_RST,
    input  logic                    A_START,
    output logic                    A_BUSY,
    output logic                    A_DONE,
    output logic                    A_FAIL,
    output logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_FAIL_DATA,
    input  logic [P_DATA_WIDTH-1:0] A_MEM_DOUT,
    output logic                    A_BIST_EN,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN
);

    state_e                  state, state_nx;
    logic [2:0]              elem;
    logic                    opi;
    logic                    last_issued;
    march_elem_t             cur, nxt;
    op_e                     cur_op;
    logic                    cur_rd;

    logic [P_ADDR_WIDTH-1:0] ag_addr;
    logic                    ag_first, ag_last, ag_load, ag_load_down, ag_step;

    logic                    start_ok, mismatch, issue, clear;
    logic                    addr_done, elem_done, adv_elem, adv_pass, final_op;
    logic [P_DATA_WIDTH-1:0] op_data, exp_d, exp_q;
    logic [P_ADDR_WIDTH-1:0] addr_q;
    logic                    rd_vld_q;

`ifdef SRAM_BIST_CKBD_EN
    logic pass;
    logic final_pass;
    assign final_pass = pass;
`else
    localparam logic pass       = 1'b0;
    localparam logic final_pass = 1'b1;
`endif

    // Solid background, or alternating 0101.. flipped on odd addresses.
    function automatic logic [P_DATA_WIDTH-1:0] march_data(input logic ckbd,
                                                           input logic d1,
                                                           input logic a0);
        logic [P_DATA_WIDTH-1:0] base;
        for (int i = 0; i < P_DATA_WIDTH; i++) begin
            base[i] = ckbd & ((i % 2 == 0) ^ a0);
        end
        return d1 ? ~base : base;
    endfunction

    sram_bist_addr_gen #(.P_ADDR_WIDTH(P_ADDR_WIDTH)) u_addr_gen (
        .clk       (A_CLK),
        .rst       (A_RST),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .down      (cur.down),
        .addr      (ag_addr),
        .first     (ag_first),
        .last      (ag_last)
    );

    assign cur       = march_elem(elem);
    assign nxt       = march_elem(elem + 3'd1);
    assign cur_op    = opi ? cur.op1 : cur.op0;
    assign cur_rd    = op_is_read(cur_op);
    assign op_data   = march_data(pass, op_data_sel(cur_op), ag_addr[0]);

    // The first op of any element sits at ag_first with opi clear.
    assign addr_done = !cur.two_ops || opi;
    assign elem_done = addr_done && ag_last;

    assign start_ok  = A_START && (state == ST_IDLE || state == ST_DONE);
    assign mismatch  = rd_vld_q && (A_MEM_DOUT != exp_q);
    assign issue     = (start_ok && ag_first && !opi)
                     || (state == ST_RUN && !last_issued && !mismatch);

    assign adv_elem  = issue && elem_done && (elem != C_LAST_ELEM);
    assign adv_pass  = issue && elem_done && (elem == C_LAST_ELEM) && !final_pass;
    assign final_op  = issue && elem_done && (elem == C_LAST_ELEM) && final_pass;

    assign clear        = (state_nx == ST_DONE);
    assign ag_load      = clear || adv_elem || adv_pass;
    assign ag_load_down = adv_elem && nxt.down;
    assign ag_step      = issue && addr_done && !ag_last;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start_ok) state_nx = ST_RUN;
            ST_RUN: begin
                if (mismatch)         state_nx = ST_DONE;
                else if (last_issued) state_nx = ST_DRAIN;
            end
            ST_DRAIN: state_nx = ST_DONE;
            ST_DONE:  if (start_ok) state_nx = ST_RUN;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge A_CLK) begin
        if (A_RST || clear) begin
            elem        <= '0;
            opi         <= 1'b0;
            last_issued <= 1'b0;
        end else if (issue) begin
            opi <= !addr_done;
            if (adv_elem)      elem <= elem + 3'd1;
            else if (adv_pass) elem <= '0;
            if (final_op)      last_issued <= 1'b1;
        end
    end

`ifdef SRAM_BIST_CKBD_EN
    always_ff @(posedge A_CLK) begin
        if (A_RST || clear) pass <= 1'b0;
        else if (adv_pass)  pass <= 1'b1;
    end
`endif

    // Op outputs, then one stage holding expected data/address for the compare.
    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            state       <= ST_IDLE;
            A_BUSY      <= 1'b0;
            A_DONE      <= 1'b0;
            A_FAIL      <= 1'b0;
            A_FAIL_ADDR <= '0;
            A_FAIL_DATA <= '0;
            A_BIST_EN   <= 1'b0;
            A_BIST_ADDR <= '0;
            A_BIST_DIN  <= '0;
            A_BIST_BM   <= '0;
            A_BIST_MEN  <= 1'b0;
            A_BIST_WEN  <= 1'b0;
            A_BIST_REN  <= 1'b0;
            exp_d       <= '0;
            exp_q       <= '0;
            addr_q      <= '0;
            rd_vld_q    <= 1'b0;
        end else begin
            state       <= state_nx;
            A_BUSY      <= (state_nx == ST_RUN) || (state_nx == ST_DRAIN);
            A_DONE      <= (state_nx == ST_DONE);
            A_BIST_EN   <= issue;
            A_BIST_MEN  <= issue;
            A_BIST_WEN  <= issue && !cur_rd;
            A_BIST_REN  <= issue && cur_rd;
            A_BIST_BM   <= {P_DATA_WIDTH{issue}};
            A_BIST_ADDR <= issue ? ag_addr : '0;
            A_BIST_DIN  <= (issue && !cur_rd) ? op_data : '0;
            exp_d       <= (issue && cur_rd) ? op_data : '0;
            rd_vld_q    <= A_BIST_REN && !mismatch;
            exp_q       <= exp_d;
            addr_q      <= A_BIST_ADDR;
            if (start_ok) begin
                A_FAIL      <= 1'b0;
                A_FAIL_ADDR <= '0;
                A_FAIL_DATA <= '0;
            end else if (mismatch) begin
                A_FAIL      <= 1'b1;
                A_FAIL_ADDR <= addr_q;
                A_FAIL_DATA <= A_MEM_DOUT;
            end
        end
    end

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Bench for sram_march_bist_ctrl with a 1P macro model and a read-path fault
// injector; honours SRAM_BIST_CKBD_EN for the second-pass expectations.
module tb_sram_march_bist_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 1 << AW;
`ifdef SRAM_BIST_CKBD_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int OPS = 10 * N * PASSES;

    typedef struct {
        int addr;
        bit wen;
        bit ren;
        int din;
        int bm;
    } op_t;

    logic          A_CLK = 1'b0;
    logic          A_RST = 1'b1;
    logic          A_START = 1'b0;
    logic          A_BUSY, A_DONE, A_FAIL;
    logic [AW-1:0] A_FAIL_ADDR;
    logic [DW-1:0] A_FAIL_DATA;
    logic [DW-1:0] A_MEM_DOUT;
    logic          A_BIST_EN;
    logic [AW-1:0] A_BIST_ADDR;
    logic [DW-1:0] A_BIST_DIN, A_BIST_BM;
    logic          A_BIST_MEN, A_BIST_WEN, A_BIST_REN;

    int  n_assert = 0;
    int  n_fail   = 0;
    int  both_cnt = 0;
    int  en_bad   = 0;
    int  last_tb0 = 0;
    op_t ref_ops[$];
    op_t trace[$];

    logic [DW-1:0] mem [N];
    logic          flt_en   = 1'b0;
    int            flt_addr = 0;
    int            flt_bit  = 0;
    logic          flt_val  = 1'b0;

    sram_march_bist_ctrl #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) dut (
        .A_CLK       (A_CLK),
        .A_RST       (A_RST),
        .A_START     (A_START),
        .A_BUSY      (A_BUSY),
        .A_DONE      (A_DONE),
        .A_FAIL      (A_FAIL),
        .A_FAIL_ADDR (A_FAIL_ADDR),
        .A_FAIL_DATA (A_FAIL_DATA),
        .A_MEM_DOUT  (A_MEM_DOUT),
        .A_BIST_EN   (A_BIST_EN),
        .A_BIST_ADDR (A_BIST_ADDR),
        .A_BIST_DIN  (A_BIST_DIN),
        .A_BIST_BM   (A_BIST_BM),
        .A_BIST_MEN  (A_BIST_MEN),
        .A_BIST_WEN  (A_BIST_WEN),
        .A_BIST_REN  (A_BIST_REN)
    );

    always #5 A_CLK = ~A_CLK;

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        d = mem[a];
        if (flt_en && int'(a) == flt_addr) d[flt_bit] = flt_val;
        return d;
    endfunction

    // Behavioural 1P macro: op sampled at the edge, read data valid after it.
    always @(posedge A_CLK) begin
        if (A_BIST_EN && A_BIST_MEN && A_BIST_WEN)
            mem[A_BIST_ADDR] <= (A_BIST_DIN & A_BIST_BM) | (mem[A_BIST_ADDR] & ~A_BIST_BM);
        if (A_BIST_EN && A_BIST_MEN && A_BIST_REN)
            A_MEM_DOUT <= model_rd(A_BIST_ADDR);
    end

    always @(negedge A_CLK) begin
        if (A_BIST_MEN) begin
            trace.push_back('{addr: int'(A_BIST_ADDR), wen: A_BIST_WEN, ren: A_BIST_REN,
                              din: int'(A_BIST_DIN), bm: int'(A_BIST_BM)});
            if (A_BIST_WEN && A_BIST_REN) both_cnt++;
            if (!A_BIST_EN) en_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int dval(input int pass, input int d1, input int a);
        int base;
        base = (pass != 0) ? (((a % 2) != 0) ? 'hAA : 'h55) : 0;
        return (d1 != 0) ? (base ^ 'hFF) : base;
    endfunction

    // March C-: op codes 0=w0 1=w1 2=r0 3=r1, -1 = none.
    function automatic void build_ref();
        int el_down [6] = '{0, 0, 0, 1, 1, 0};
        int el_ops [6][2] = '{'{0, -1}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, -1}};
        ref_ops.delete();
        for (int p = 0; p < PASSES; p++)
            for (int e = 0; e < 6; e++)
                for (int k = 0; k < N; k++)
                    for (int j = 0; j < 2; j++) begin
                        int a, op;
                        a  = (el_down[e] != 0) ? (N - 1 - k) : k;
                        op = el_ops[e][j];
                        if (op >= 0)
                            ref_ops.push_back('{addr: a, wen: (op < 2), ren: (op >= 2),
                                                din: dval(p, op % 2, a), bm: 'hFF});
                    end
    endfunction

    // Index of the first failing read in the op stream, or -1 on a clean pass.
    function automatic int predict_fail(output int fa, output int fd);
        int sh [N];
        fa = 0;
        fd = 0;
        for (int i = 0; i < ref_ops.size(); i++) begin
            if (ref_ops[i].wen) begin
                sh[ref_ops[i].addr] = ref_ops[i].din;
            end else begin
                int obs;
                obs = sh[ref_ops[i].addr];
                if (flt_en && ref_ops[i].addr == flt_addr)
                    obs = flt_val ? (obs | (1 << flt_bit)) : (obs & ~(1 << flt_bit));
                if (obs != ref_ops[i].din) begin
                    fa = ref_ops[i].addr;
                    fd = obs;
                    return i;
                end
            end
        end
        return -1;
    endfunction

    task automatic run_test(input string tag, input int restart_at);
        int e, fidx, fa, fd, exp_edge, exp_ops, tb0, b0, en0, bad, nt;
        fidx     = predict_fail(fa, fd);
        exp_edge = (fidx < 0) ? OPS + 1 : fidx + 2;
        exp_ops  = (fidx < 0) ? OPS : ((fidx + 2 < OPS) ? fidx + 2 : OPS);
        tb0      = trace.size();
        last_tb0 = tb0;
        b0       = both_cnt;
        en0      = en_bad;
        @(negedge A_CLK) A_START = 1'b1;
        @(posedge A_CLK);
        @(negedge A_CLK) A_START = 1'b0;
        chk({tag, "_busy_e0"}, A_BUSY, 1);
        chk({tag, "_fail_clr"}, {A_FAIL, A_FAIL_ADDR, A_FAIL_DATA}, 0);
        e = 0;
        while (!A_DONE && e < OPS + 20) begin
            A_START = (e == restart_at);
            @(posedge A_CLK);
            e++;
            @(negedge A_CLK);
        end
        A_START = 1'b0;
        chk({tag, "_done_edge"}, e, exp_edge);
        chk({tag, "_done"}, A_DONE, 1);
        chk({tag, "_idle_outs"}, {A_BUSY, A_BIST_EN, A_BIST_MEN, A_BIST_BM}, 0);
        chk({tag, "_fail"}, A_FAIL, (fidx >= 0));
        if (fidx >= 0) begin
            chk({tag, "_fail_addr"}, A_FAIL_ADDR, fa);
            chk({tag, "_fail_data"}, A_FAIL_DATA, fd);
        end
        nt = trace.size() - tb0;
        chk({tag, "_n_ops"}, nt, exp_ops);
        bad = 0;
        for (int i = 0; i < nt && i < ref_ops.size(); i++) begin
            op_t o, r;
            o = trace[tb0 + i];
            r = ref_ops[i];
            if (o.addr != r.addr || o.wen != r.wen || o.ren != r.ren || o.bm != r.bm ||
                (r.wen && o.din != r.din)) bad++;
        end
        chk({tag, "_op_trace"}, bad, 0);
        chk({tag, "_rw_excl"}, both_cnt - b0, 0);
        chk({tag, "_men_en"}, en_bad - en0, 0);
        if (fidx < 0) begin
            bad = 0;
            for (int a = 0; a < N; a++)
                if (int'(mem[a]) != dval(PASSES - 1, 0, a)) bad++;
            chk({tag, "_mem_final"}, bad, 0);
        end
    endtask

    initial begin
        build_ref();

        repeat (3) @(posedge A_CLK);
        @(negedge A_CLK);
        chk("reset_outs", {A_BUSY, A_DONE, A_FAIL, A_FAIL_ADDR, A_FAIL_DATA, A_BIST_EN,
                           A_BIST_ADDR, A_BIST_DIN, A_BIST_BM, A_BIST_MEN, A_BIST_WEN,
                           A_BIST_REN}, 0);
        A_RST = 1'b0;

        // Clean pass with a start pulse while busy.
        run_test("pass", 37);
        chk("first_op", {trace[last_tb0].addr[7:0], 7'd0, trace[last_tb0].wen,
                         trace[last_tb0].din[7:0]}, {8'd0, 7'd0, 1'b1, 8'd0});
        chk("e3_first_op", {trace[last_tb0 + 80].addr[7:0], 7'd0, trace[last_tb0 + 80].ren},
            {8'd15, 7'd0, 1'b1});
`ifdef SRAM_BIST_CKBD_EN
        chk("ckbd_even", trace[last_tb0 + 10 * N].din, 'h55);
        chk("ckbd_odd", trace[last_tb0 + 10 * N + 1].din, 'hAA);
`endif

        // Bit 3 read as 0 at address 5: first r1 there fails.
        flt_en   = 1'b1;
        flt_addr = 5;
        flt_bit  = 3;
        flt_val  = 1'b0;
        run_test("stuck5", -1);
        chk("stuck5_addr_const", A_FAIL_ADDR, 5);
        chk("stuck5_data_const", A_FAIL_DATA, 'hF7);

        // Reset mid-test at cycle 60, then a normal pass.
        flt_en = 1'b0;
        @(negedge A_CLK) A_START = 1'b1;
        @(posedge A_CLK);
        @(negedge A_CLK) A_START = 1'b0;
        repeat (59) @(negedge A_CLK);
        A_RST = 1'b1;
        @(negedge A_CLK);
        chk("midrst_outs", {A_BUSY, A_DONE, A_FAIL, A_FAIL_ADDR, A_FAIL_DATA, A_BIST_EN,
                            A_BIST_ADDR, A_BIST_DIN, A_BIST_BM, A_BIST_MEN, A_BIST_WEN,
                            A_BIST_REN}, 0);
        A_RST = 1'b0;
        run_test("after_rst", -1);

        // Random read-path stuck bits with random restart pulses.
        for (int t = 0; t < 6; t++) begin
            flt_en   = 1'b1;
            flt_addr = $urandom_range(0, N - 1);
            flt_bit  = $urandom_range(0, DW - 1);
            flt_val  = 1'($urandom_range(0, 1));
            run_test($sformatf("rnd%0d", t), $urandom_range(1, 60));
        end

        flt_en = 1'b0;
        run_test("final_pass", $urandom_range(1, 150));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
